// File: rtl/lfsr_pattern_source.sv
`default_nettype none
// ============================================================================
// Module      : lfsr_pattern_source
// Description : Stimulus source for the bit-statistics counter. A Fibonacci
//               LFSR emits a pseudo-random bit stream on msb; max_tick pulses
//               for one cycle each time the register returns to SEED after a
//               full period; fsm_out pulses one cycle after the last CW_LEN
//               emitted bits equal CODEWORD (overlapping detection).
// Ports       : clk        in  1      rising-edge clock
//               rst_n      in  1      synchronous active-low reset
//               step_en    in  1      step qualifier (LFSR_STEP_EN builds only)
//               msb        out 1      lfsr[WIDTH-1], bit emitted this cycle
//               max_tick   out 1      one-cycle pulse, LFSR wrapped to SEED
//               fsm_out    out 1      one-cycle pulse, codeword just completed
//               lfsr_state out WIDTH  current LFSR register
//               step_cnt   out WIDTH  steps since last wrap or reset
// Macro       : LFSR_STEP_EN adds the step_en input; otherwise it steps
//               every cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module lfsr_pattern_source #(
  parameter int                WIDTH    = 16,
  parameter logic [WIDTH-1:0]  TAPS     = 16'hB400,
  parameter logic [WIDTH-1:0]  SEED     = 16'hACE1,
  parameter int                CW_LEN   = 4,
  parameter logic [CW_LEN-1:0] CODEWORD = 4'b1011
) (
  input  logic             clk,
  input  logic             rst_n,
`ifdef LFSR_STEP_EN
  input  logic             step_en,
`endif
  output logic             msb,
  output logic             max_tick,
  output logic             fsm_out,
  output logic [WIDTH-1:0] lfsr_state,
  output logic [WIDTH-1:0] step_cnt
);

  // Width of the fill counter; it only needs to reach CW_LEN-1.
  localparam int             FW        = $clog2(CW_LEN);
  localparam logic [FW-1:0]  FILL_LAST = FW'(CW_LEN - 2);
  localparam logic [FW-1:0]  FILL_ONE  = FW'(1);
  localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);

  localparam logic [0:0] S_FILL = 1'b0;
  localparam logic [0:0] S_HUNT = 1'b1;

  // Illegal builds are rejected at elaboration.
  if (SEED == '0) begin : g_bad_seed
    $error("lfsr_pattern_source: SEED must be nonzero (all-zero lockup)");
  end
  if (CW_LEN < 2 || CW_LEN > 8) begin : g_bad_cw_len
    $error("lfsr_pattern_source: CW_LEN must be in 2..8");
  end

  logic              step;
  logic [WIDTH-1:0]  lfsr_q, lfsr_d;
  logic [WIDTH-1:0]  step_cnt_q, step_cnt_d;
  logic              max_tick_q, max_tick_d;
  logic              fsm_out_q, fsm_out_d;
  logic [CW_LEN-2:0] hist_q, hist_d;
  logic [FW-1:0]     fill_q, fill_d;
  logic [0:0]        state_q, state_d;
  logic              fb;
  logic [CW_LEN-1:0] window;

`ifdef LFSR_STEP_EN
  assign step = step_en;
`else
  assign step = 1'b1;
`endif

  assign fb     = ^(lfsr_q & TAPS);
  // Window of the last CW_LEN emitted bits including the one on msb now;
  // oldest bit lands in the MSB, matching CODEWORD's bit order.
  assign window = {hist_q, lfsr_q[WIDTH-1]};

  always_comb begin
    lfsr_d     = lfsr_q;
    step_cnt_d = step_cnt_q;
    max_tick_d = 1'b0;
    fsm_out_d  = 1'b0;
    hist_d     = hist_q;
    fill_d     = fill_q;
    state_d    = state_q;
    if (step) begin
      lfsr_d     = {lfsr_q[WIDTH-2:0], fb};
      // Tick and counter wrap coincide with the cycle SEED is reloaded.
      max_tick_d = (lfsr_d == SEED);
      step_cnt_d = max_tick_d ? '0 : (step_cnt_q + CNT_ONE);
      hist_d     = window[CW_LEN-2:0];
      case (state_q)
        S_FILL: begin
          fill_d = fill_q + FILL_ONE;
          if (fill_q == FILL_LAST) begin
            state_d = S_HUNT;
          end
        end
        default: begin
          fsm_out_d = (window == CODEWORD);
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lfsr_q     <= SEED;
      step_cnt_q <= '0;
      max_tick_q <= 1'b0;
      fsm_out_q  <= 1'b0;
      hist_q     <= '0;
      fill_q     <= '0;
      state_q    <= S_FILL;
    end else begin
      lfsr_q     <= lfsr_d;
      step_cnt_q <= step_cnt_d;
      max_tick_q <= max_tick_d;
      fsm_out_q  <= fsm_out_d;
      hist_q     <= hist_d;
      fill_q     <= fill_d;
      state_q    <= state_d;
    end
  end

  assign msb        = lfsr_q[WIDTH-1];
  assign max_tick   = max_tick_q;
  assign fsm_out    = fsm_out_q;
  assign lfsr_state = lfsr_q;
  assign step_cnt   = step_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_lfsr_pattern_source.sv
`default_nettype none
// ============================================================================
// Module      : tb_lfsr_pattern_source
// Description : Self-checking bench for lfsr_pattern_source (default
//               parameters). A behavioural model tracks the emitted bit
//               history and the step count since reset; every cycle all
//               outputs are compared against it.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lfsr_pattern_source;

  localparam int          CW_LEN   = 4;
  localparam logic [15:0] TAPS     = 16'hB400;
  localparam logic [15:0] SEED     = 16'hACE1;
  localparam logic [3:0]  CODEWORD = 4'b1011;
  localparam int          PERIOD   = 65535;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        step_en;
  logic        msb, max_tick, fsm_out;
  logic [15:0] lfsr_state, step_cnt;

  always #5 clk = ~clk;

  lfsr_pattern_source dut (
    .clk        (clk),
    .rst_n      (rst_n),
`ifdef LFSR_STEP_EN
    .step_en    (step_en),
`endif
    .msb        (msb),
    .max_tick   (max_tick),
    .fsm_out    (fsm_out),
    .lfsr_state (lfsr_state),
    .step_cnt   (step_cnt)
  );

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model state
  logic [15:0] m_lfsr;
  int unsigned m_n;        // steps taken since reset
  bit          m_hist[$];  // last emitted bits, oldest first
  logic        m_tick, m_fsm;

  bit seen [0:65535];

  function automatic logic [15:0] next_state(input logic [15:0] s);
    int c;
    c = $countones(s & TAPS);
    return {s[14:0], c[0]};
  endfunction

  function automatic bit model_step(input logic e);
`ifdef LFSR_STEP_EN
    return e;
`else
    return 1'b1;
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    chk("lfsr_state", {16'h0, lfsr_state}, {16'h0, m_lfsr});
    chk("msb",        {31'h0, msb},        {31'h0, m_lfsr[15]});
    chk("step_cnt",   {16'h0, step_cnt},   m_n % PERIOD);
    chk("max_tick",   {31'h0, max_tick},   {31'h0, m_tick});
    chk("fsm_out",    {31'h0, fsm_out},    {31'h0, m_fsm});
  endtask

  // One clock: apply inputs, advance model by that edge, check at negedge.
  task automatic cycle(input logic r, input logic e);
    logic [3:0] w;
    rst_n   = r;
    step_en = e;
    @(posedge clk);
    if (!r) begin
      m_lfsr = SEED; m_n = 0; m_hist.delete(); m_tick = 1'b0; m_fsm = 1'b0;
    end else if (model_step(e)) begin
      m_hist.push_back(m_lfsr[15]);
      if (m_hist.size() > CW_LEN) void'(m_hist.pop_front());
      w = '0;
      foreach (m_hist[i]) w = {w[2:0], m_hist[i]};
      m_fsm  = (m_hist.size() == CW_LEN) && (w == CODEWORD);
      m_lfsr = next_state(m_lfsr);
      m_n++;
      m_tick = (m_n % PERIOD) == 0;
    end else begin
      m_tick = 1'b0; m_fsm = 1'b0;
    end
    @(negedge clk);
    check_outputs();
  endtask

  int          ones, zeros, repeats, ticks;
  logic [15:0] saved_lfsr, saved_cnt;

  initial begin
    rst_n   = 1'b0;
    step_en = 1'b1;
    m_lfsr  = SEED; m_n = 0; m_tick = 1'b0; m_fsm = 1'b0;

    // Reset state
    cycle(1'b0, 1'b1);
    cycle(1'b0, 1'b1);
    chk("rst_lfsr", {16'h0, lfsr_state}, 32'hACE1);
    chk("rst_msb",  {31'h0, msb},        32'h1);
    chk("rst_cnt",  {16'h0, step_cnt},   32'h0);
    chk("rst_tick", {31'h0, max_tick},   32'h0);
    chk("rst_fsm",  {31'h0, fsm_out},    32'h0);

    // Statistics over the first period start with the SEED cycle.
    ones = 1; zeros = 0; repeats = 0; ticks = 0;
    seen[SEED] = 1'b1;

    // First step
    cycle(1'b1, 1'b1);
    chk("step1_lfsr", {16'h0, lfsr_state}, 32'h59C3);
    chk("step1_msb",  {31'h0, msb},        32'h0);
    chk("step1_cnt",  {16'h0, step_cnt},   32'h1);
    chk("step1_tick", {31'h0, max_tick},   32'h0);
    if (msb) ones++; else zeros++;
    if (seen[lfsr_state]) repeats++;
    seen[lfsr_state] = 1'b1;

    // Remainder of the first full period
    while (m_n < PERIOD) begin
      cycle(1'b1, 1'b1);
      if (max_tick) ticks++;
      if (m_n < PERIOD) begin
        if (msb) ones++; else zeros++;
        if (seen[lfsr_state]) repeats++;
        seen[lfsr_state] = 1'b1;
      end
    end
    chk("wrap_tick",  {31'h0, max_tick},   32'h1);
    chk("wrap_lfsr",  {16'h0, lfsr_state}, 32'hACE1);
    chk("wrap_cnt",   {16'h0, step_cnt},   32'h0);
    chk("wrap_ticks", ticks,               32'd1);
    chk("ones",       ones,                32'd32768);
    chk("zeros",      zeros,               32'd32767);
    chk("repeats",    repeats,             32'd0);

    // Windows spanning the wrap continue to be detected.
    repeat (20) cycle(1'b1, 1'b1);

    // Mid-run reset at step 1000
    cycle(1'b0, 1'b1);
    repeat (1000) cycle(1'b1, 1'b1);
    cycle(1'b0, 1'b1);
    chk("mrst_lfsr", {16'h0, lfsr_state}, 32'hACE1);
    chk("mrst_cnt",  {16'h0, step_cnt},   32'h0);
    chk("mrst_tick", {31'h0, max_tick},   32'h0);
    chk("mrst_fsm",  {31'h0, fsm_out},    32'h0);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 1'b1);
      chk("post_rst_fsm", {31'h0, fsm_out}, 32'h0);
    end

`ifdef LFSR_STEP_EN
    // Freeze for 10 cycles, then resume.
    repeat (20) cycle(1'b1, 1'b1);
    saved_lfsr = m_lfsr;
    saved_cnt  = 16'(m_n % PERIOD);
    for (int i = 0; i < 10; i++) begin
      cycle(1'b1, 1'b0);
      chk("frz_lfsr", {16'h0, lfsr_state}, {16'h0, saved_lfsr});
      chk("frz_cnt",  {16'h0, step_cnt},   {16'h0, saved_cnt});
      chk("frz_tick", {31'h0, max_tick},   32'h0);
      chk("frz_fsm",  {31'h0, fsm_out},    32'h0);
    end
    repeat (20) cycle(1'b1, 1'b1);
`else
    saved_lfsr = '0;
    saved_cnt  = '0;
`endif

    // Randomized tail: sparse resets, random step gating where available.
    for (int i = 0; i < 3000; i++) begin
      cycle(($urandom_range(0, 499) != 0) ? 1'b1 : 1'b0,
            ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
